button_event_ctrl: RTL and testbench

- Multi-button input controller: synchronises and debounces NumBtns raw button inputs using one shared sample-tick prescaler.
- Detects press, release and long-press events per button.
- Arbitrates simultaneous events round-robin into a small event FIFO with a valid/ready pop interface, and raises an interrupt.
- Sits between board button pins and a bus-facing peripheral register block.

---
 rtl/button_event_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_button_event_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_event_ctrl.sv
// button_event_ctrl
//   Multi-button front end: two-flop synchronisers, one shared debounce
//   sample-tick prescaler, per-button debounce and long-press detection,
//   round-robin arbitration of per-button pending events into a small
//   first-word-fall-through event FIFO, sticky overflow flag and interrupt.
//
// Ports
//   clk_i          clock
//   rst_i          asynchronous active-high reset
//   btn_i          raw button levels (1 = pressed), asynchronous to clk_i
//   btn_state_o    debounced button levels
//   evt_valid_o    FIFO head holds an event
//   evt_ready_i    consumer accepts the head event this cycle
//   evt_btn_o      button index of the head event (0 while FIFO empty)
//   evt_type_o     01 press, 10 release, 11 long-press (0 while FIFO empty)
//   overflow_o     sticky, set when an event had to be dropped
//   clr_overflow_i clears overflow_o (a simultaneous set wins)
//   irq_o          evt_valid_o | overflow_o
module button_event_ctrl #(
  parameter int NumBtns     = 4,
  parameter int TickDiv     = 100,
  parameter int StableTicks = 5,
  parameter int LongTicks   = 200,
  parameter int FifoDepth   = 4
) (
  input  logic                                           clk_i,
  input  logic                                           rst_i,
  input  logic [NumBtns-1:0]                             btn_i,
  output logic [NumBtns-1:0]                             btn_state_o,
  output logic                                           evt_valid_o,
  input  logic                                           evt_ready_i,
  output logic [((NumBtns > 1) ? $clog2(NumBtns) : 1)-1:0] evt_btn_o,
  output logic [1:0]                                     evt_type_o,
  output logic                                           overflow_o,
  input  logic                                           clr_overflow_i,
  output logic                                           irq_o
);

  localparam int BW = (NumBtns > 1) ? $clog2(NumBtns) : 1;
  localparam int PW = (TickDiv > 1) ? $clog2(TickDiv) : 1;
  localparam int SW = (StableTicks > 1) ? $clog2(StableTicks) : 1;
  localparam int HW = $clog2(LongTicks + 1);
  localparam int AW = $clog2(FifoDepth);

  localparam logic [PW-1:0] TickLast = PW'(TickDiv - 1);
  localparam logic [SW-1:0] StabLast = SW'(StableTicks - 1);
  localparam logic [HW-1:0] HoldPre  = HW'(LongTicks - 1);
  localparam logic [HW-1:0] HoldMax  = HW'(LongTicks);
  localparam logic [BW-1:0] RrLast   = BW'(NumBtns - 1);

  localparam logic [1:0] EvPress   = 2'b01;
  localparam logic [1:0] EvRelease = 2'b10;
  localparam logic [1:0] EvLong    = 2'b11;

  // Hold counter stops at LongTicks so the long-press fires only once.
  function automatic logic [HW-1:0] sat_inc_hold(input logic [HW-1:0] v);
    return (v == HoldMax) ? v : v + 1'b1;
  endfunction

  logic [NumBtns-1:0] r_sync1, r_sync2, r_state, r_pend;
  logic [PW-1:0]      r_presc;
  logic [SW-1:0]      r_stab  [NumBtns];
  logic [HW-1:0]      r_hold  [NumBtns];
  logic [1:0]         r_ptype [NumBtns];
  logic [BW-1:0]      r_rr;
  logic [AW:0]        r_wr, r_rd;
  logic [BW-1:0]      r_mem_btn  [FifoDepth];
  logic [1:0]         r_mem_type [FifoDepth];
  logic               r_ovf;

  logic               w_tick;
  logic [NumBtns-1:0] w_flip, w_long, w_new, w_gnt_oh;
  logic [1:0]         w_ntype [NumBtns];
  logic               w_hi_vld, w_gnt_vld;
  logic [BW-1:0]      w_hi_idx, w_lo_idx, w_gnt_idx;
  logic [1:0]         w_hi_type, w_lo_type, w_gnt_type;
  logic               w_empty, w_full, w_pop, w_push, w_drop, w_ovw;

  assign w_tick = (r_presc == TickLast);

  // Event detection. A release flip and a long-press can only coincide
  // while the level is 1; the type mux lets the release win.
  always_comb begin
    w_flip = '0;
    w_long = '0;
    for (int i = 0; i < NumBtns; i++) begin
      w_flip[i]  = w_tick && (r_sync2[i] != r_state[i]) && (r_stab[i] == StabLast);
      w_long[i]  = w_tick && r_state[i] && (r_hold[i] == HoldPre);
      w_ntype[i] = w_flip[i] ? (r_sync2[i] ? EvPress : EvRelease) : EvLong;
    end
    w_new = w_flip | w_long;
  end

  // Round-robin: the lowest pending index at or above r_rr wins; if there
  // is none, the lowest pending index overall (which lies below r_rr).
  // Scanning downwards leaves the lowest match in the variables.
  always_comb begin
    w_hi_vld  = 1'b0;
    w_hi_idx  = '0;
    w_hi_type = '0;
    w_lo_idx  = '0;
    w_lo_type = '0;
    for (int i = NumBtns - 1; i >= 0; i--) begin
      if (r_pend[i]) begin
        w_lo_idx  = BW'(i);
        w_lo_type = r_ptype[i];
        if (BW'(i) >= r_rr) begin
          w_hi_vld  = 1'b1;
          w_hi_idx  = BW'(i);
          w_hi_type = r_ptype[i];
        end
      end
    end
    w_gnt_vld  = |r_pend;
    w_gnt_idx  = w_hi_vld ? w_hi_idx : w_lo_idx;
    w_gnt_type = w_hi_vld ? w_hi_type : w_lo_type;
    w_gnt_oh   = '0;
    for (int i = 0; i < NumBtns; i++) begin
      w_gnt_oh[i] = w_gnt_vld && (w_gnt_idx == BW'(i));
    end
  end

  // Pointers carry one extra wrap bit to tell full from empty.
  assign w_empty = (r_wr == r_rd);
  assign w_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_pop   = ~w_empty & evt_ready_i;
  assign w_push  = w_gnt_vld & (~w_full | w_pop);
  assign w_drop  = w_gnt_vld & ~w_push;
  // A slot being granted this cycle is free to take a new event.
  assign w_ovw   = |(w_new & r_pend & ~w_gnt_oh);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_state <= '0;
      r_pend  <= '0;
      r_presc <= '0;
      r_rr    <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_ovf   <= 1'b0;
      for (int i = 0; i < NumBtns; i++) begin
        r_stab[i] <= '0;
        r_hold[i] <= '0;
      end
    end else begin
      r_sync1 <= btn_i;
      r_sync2 <= r_sync1;
      r_presc <= w_tick ? '0 : r_presc + 1'b1;

      for (int i = 0; i < NumBtns; i++) begin
        // Any cycle agreeing with the accepted level restarts the debounce.
        if (r_sync2[i] == r_state[i]) begin
          r_stab[i] <= '0;
        end else if (w_tick) begin
          r_stab[i] <= (r_stab[i] == StabLast) ? '0 : r_stab[i] + 1'b1;
        end
        if (w_flip[i]) begin
          r_state[i] <= r_sync2[i];
        end

        if (!r_state[i]) begin
          r_hold[i] <= '0;
        end else if (w_tick) begin
          r_hold[i] <= sat_inc_hold(r_hold[i]);
        end

        if (w_new[i]) begin
          r_pend[i] <= 1'b1;
        end else if (w_gnt_oh[i]) begin
          r_pend[i] <= 1'b0;
        end
      end

      if (w_gnt_vld) begin
        r_rr <= (w_gnt_idx == RrLast) ? '0 : w_gnt_idx + 1'b1;
      end
      if (w_push) begin
        r_wr <= r_wr + 1'b1;
      end
      if (w_pop) begin
        r_rd <= r_rd + 1'b1;
      end

      if (w_drop || w_ovw) begin
        r_ovf <= 1'b1;
      end else if (clr_overflow_i) begin
        r_ovf <= 1'b0;
      end
    end
  end

  // Event payload storage; only read where the matching valid flag is set.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NumBtns; i++) begin
      if (w_new[i]) begin
        r_ptype[i] <= w_ntype[i];
      end
    end
    if (w_push) begin
      r_mem_btn[r_wr[AW-1:0]]  <= w_gnt_idx;
      r_mem_type[r_wr[AW-1:0]] <= w_gnt_type;
    end
  end

  assign btn_state_o = r_state;
  assign evt_valid_o = ~w_empty;
  assign evt_btn_o   = w_empty ? '0 : r_mem_btn[r_rd[AW-1:0]];
  assign evt_type_o  = w_empty ? '0 : r_mem_type[r_rd[AW-1:0]];
  assign overflow_o  = r_ovf;
  assign irq_o       = ~w_empty | r_ovf;

endmodule

// File: tb/tb_button_event_ctrl.sv
// Testbench for button_event_ctrl: directed scenarios plus randomized
// button/consumer activity, compared every cycle against a behavioural
// model (integer counters, event queue as FIFO).
module tb_button_event_ctrl;
  localparam int NB = 2;
  localparam int TD = 4;
  localparam int ST = 3;
  localparam int LT = 8;
  localparam int FD = 2;

  logic          clk   = 1'b0;
  logic          rst   = 1'b1;
  logic [NB-1:0] btn   = '0;
  logic          ready = 1'b0;
  logic          clr   = 1'b0;
  logic [NB-1:0] state;
  logic          valid;
  logic [0:0]    ebtn;
  logic [1:0]    etype;
  logic          ovf;
  logic          irq;

  button_event_ctrl #(
    .NumBtns(NB), .TickDiv(TD), .StableTicks(ST), .LongTicks(LT), .FifoDepth(FD)
  ) dut (
    .clk_i(clk), .rst_i(rst), .btn_i(btn), .btn_state_o(state),
    .evt_valid_o(valid), .evt_ready_i(ready), .evt_btn_o(ebtn),
    .evt_type_o(etype), .overflow_o(ovf), .clr_overflow_i(clr), .irq_o(irq)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  typedef struct { int b; int t; } ev_t;
  int  m_s1[NB], m_s2[NB], m_lvl[NB], m_stab[NB], m_hold[NB];
  int  m_pend[NB], m_ptype[NB];
  int  m_rr, m_pre, m_ovf;
  ev_t m_q[$];

  task automatic m_reset();
    for (int b = 0; b < NB; b++) begin
      m_s1[b] = 0; m_s2[b] = 0; m_lvl[b] = 0; m_stab[b] = 0;
      m_hold[b] = 0; m_pend[b] = 0; m_ptype[b] = 0;
    end
    m_rr = 0; m_pre = 0; m_ovf = 0;
    m_q.delete();
  endtask

  // One clock edge worth of behaviour, using the inputs present at the edge.
  task automatic m_step();
    int  tick;
    int  nev[NB];
    int  nty[NB];
    int  g;
    int  set_ovf;
    ev_t e;
    tick = (m_pre == TD - 1) ? 1 : 0;
    for (int b = 0; b < NB; b++) begin
      nev[b] = 0;
      nty[b] = 0;
      if (tick == 1 && m_s2[b] != m_lvl[b] && m_stab[b] == ST - 1) begin
        nev[b] = 1;
        nty[b] = (m_s2[b] == 1) ? 1 : 2;
      end else if (tick == 1 && m_lvl[b] == 1 && m_hold[b] == LT - 1) begin
        nev[b] = 1;
        nty[b] = 3;
      end
    end
    g = -1;
    for (int k = 0; k < NB; k++) begin
      int idx;
      idx = (m_rr + k) % NB;
      if (g < 0 && m_pend[idx] != 0) g = idx;
    end
    set_ovf = 0;
    if (m_q.size() > 0 && ready) void'(m_q.pop_front());
    if (g >= 0) begin
      e.b = g;
      e.t = m_ptype[g];
      m_pend[g] = 0;
      m_rr = (g + 1) % NB;
      if (m_q.size() < FD) m_q.push_back(e);
      else set_ovf = 1;
    end
    for (int b = 0; b < NB; b++) begin
      if (nev[b] != 0) begin
        if (m_pend[b] != 0) set_ovf = 1;
        m_pend[b]  = 1;
        m_ptype[b] = nty[b];
      end
    end
    if (set_ovf != 0) m_ovf = 1;
    else if (clr) m_ovf = 0;
    for (int b = 0; b < NB; b++) begin
      if (m_lvl[b] == 0) m_hold[b] = 0;
      else if (tick == 1 && m_hold[b] < LT) m_hold[b]++;
      if (m_s2[b] == m_lvl[b]) m_stab[b] = 0;
      else if (tick == 1) begin
        if (m_stab[b] == ST - 1) begin
          m_lvl[b]  = m_s2[b];
          m_stab[b] = 0;
        end else begin
          m_stab[b]++;
        end
      end
      m_s2[b] = m_s1[b];
      m_s1[b] = int'(btn[b]);
    end
    m_pre = (m_pre + 1) % TD;
  endtask

  task automatic check_outputs();
    int exp_state;
    int qv;
    exp_state = 0;
    for (int b = 0; b < NB; b++) exp_state |= (m_lvl[b] << b);
    qv = (m_q.size() > 0) ? 1 : 0;
    chk("btn_state", int'(state), exp_state);
    chk("evt_valid", int'(valid), qv);
    if (qv == 1) begin
      chk("evt_btn", int'(ebtn), m_q[0].b);
      chk("evt_type", int'(etype), m_q[0].t);
    end
    chk("overflow", int'(ovf), m_ovf);
    chk("irq", int'(irq), (qv == 1 || m_ovf == 1) ? 1 : 0);
  endtask

  task automatic step();
    @(posedge clk);
    m_step();
    #1;
    check_outputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Wait (bounded) for a head event, capture it, then pop it.
  task automatic pop_evt(input string tag, output int b, output int t);
    int n;
    n = 0;
    b = -1;
    t = -1;
    while (!valid && n < 200) begin
      step();
      n++;
    end
    chk({tag, "_wait"}, int'(valid), 1);
    if (valid) begin
      b = int'(ebtn);
      t = int'(etype);
      ready = 1'b1;
      step();
      ready = 1'b0;
    end
  endtask

  task automatic async_reset_check(input string tag);
    rst = 1'b1;
    #1;
    m_reset();
    chk({tag, "_state"}, int'(state), 0);
    chk({tag, "_valid"}, int'(valid), 0);
    chk({tag, "_btn"},   int'(ebtn), 0);
    chk({tag, "_type"},  int'(etype), 0);
    chk({tag, "_ovf"},   int'(ovf), 0);
    chk({tag, "_irq"},   int'(irq), 0);
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NB-1:0] tgt;
    int            dur, rmode, n, eb, et;
    int            bouncy;

    // Reset state
    m_reset();
    #1;
    chk("rst_state", int'(state), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_irq", int'(irq), 0);
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    rst = 1'b0;

    // Bounce on button 1: high phases are shorter than one tick period
    for (int c = 0; c < 40; c++) begin
      if (c % 3 == 0) btn[1] = ~btn[1];
      step();
    end
    btn[1] = 1'b0;
    run(30);
    chk("bounce_state", int'(state[1]), 0);
    chk("bounce_empty", int'(valid), 0);

    // Simultaneous press then release, round-robin from 0
    btn = 2'b11;
    pop_evt("sim_p0", eb, et);
    chk("sim_p0_btn", eb, 0);
    chk("sim_p0_type", et, 1);
    chk("sim_p1_next", int'(valid), 1);
    pop_evt("sim_p1", eb, et);
    chk("sim_p1_btn", eb, 1);
    chk("sim_p1_type", et, 1);
    btn = 2'b00;
    pop_evt("sim_r0", eb, et);
    chk("sim_r0_btn", eb, 0);
    chk("sim_r0_type", et, 2);
    pop_evt("sim_r1", eb, et);
    chk("sim_r1_btn", eb, 1);
    chk("sim_r1_type", et, 2);

    // Clean press with latency check, then long press, then release
    btn[0] = 1'b1;
    n = 0;
    while (!state[0] && n < 100) begin
      step();
      n++;
    end
    chk("lat_state", int'(state[0]), 1);
    chk("lat_e0_valid", int'(valid), 0);
    step();
    chk("lat_e1_valid", int'(valid), 1);
    pop_evt("lp_press", eb, et);
    chk("lp_press_btn", eb, 0);
    chk("lp_press_type", et, 1);
    chk("lp_popped", int'(valid), 0);
    pop_evt("lp_long", eb, et);
    chk("lp_long_btn", eb, 0);
    chk("lp_long_type", et, 3);
    run(60);
    chk("lp_no_repeat", int'(valid), 0);
    btn[0] = 1'b0;
    pop_evt("lp_rel", eb, et);
    chk("lp_rel_btn", eb, 0);
    chk("lp_rel_type", et, 2);
    run(60);
    chk("lp_quiet", int'(valid), 0);

    // Overflow: press + long fill the FIFO, the release is dropped
    btn[0] = 1'b1;
    run(70);
    btn[0] = 1'b0;
    run(30);
    chk("ovf_set", int'(ovf), 1);
    chk("ovf_irq", int'(irq), 1);
    pop_evt("ovf_e0", eb, et);
    chk("ovf_e0_type", et, 1);
    pop_evt("ovf_e1", eb, et);
    chk("ovf_e1_type", et, 3);
    chk("ovf_drained", int'(valid), 0);
    chk("ovf_irq_sticky", int'(irq), 1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("ovf_cleared", int'(ovf), 0);
    chk("ovf_irq_clear", int'(irq), 0);

    // Async reset with one queued event and another button mid-debounce
    btn[1] = 1'b1;
    n = 0;
    while (!valid && n < 100) begin
      step();
      n++;
    end
    chk("ar_queued", int'(valid), 1);
    btn[0] = 1'b1;
    run(6);
    async_reset_check("ar");
    pop_evt("ar_p0", eb, et);
    chk("ar_p0_btn", eb, 0);
    chk("ar_p0_type", et, 1);
    pop_evt("ar_p1", eb, et);
    chk("ar_p1_btn", eb, 1);
    chk("ar_p1_type", et, 1);
    btn = 2'b00;
    pop_evt("ar_r0", eb, et);
    chk("ar_r0_btn", eb, 0);
    chk("ar_r0_type", et, 2);
    pop_evt("ar_r1", eb, et);
    chk("ar_r1_btn", eb, 1);
    chk("ar_r1_type", et, 2);

    // Randomized segments: clean or bouncy levels, varied consumer rate
    for (int seg = 0; seg < 80; seg++) begin
      tgt    = NB'($urandom);
      dur    = $urandom_range(1, 70);
      rmode  = $urandom_range(0, 3);
      bouncy = ($urandom_range(0, 2) == 0) ? 1 : 0;
      if ($urandom_range(0, 19) == 0) async_reset_check("rnd_rst");
      for (int c = 0; c < dur; c++) begin
        for (int b = 0; b < NB; b++) begin
          btn[b] = (bouncy == 1 && $urandom_range(0, 3) == 0) ? ~tgt[b] : tgt[b];
        end
        ready = (rmode == 0) ? 1'b0 : ($urandom_range(0, 2) != 0);
        clr   = ($urandom_range(0, 29) == 0);
        step();
      end
    end
    ready = 1'b0;
    clr   = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
